// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register plus IDLE/MEM/WB sequencer for loads, stores and writeback.
module memory_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [13:0] control_word_ex,
   input  logic [31:0] ALU_result,
   input  logic [31:0] calculated_adr,
   input  logic [31:0] regfileb_ex,
   input  logic [31:0] pc_plus_4_ex,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_rf_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        misaligned
);
   typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
   state_t      state;
   logic [13:0] cw_q;
   logic [31:0] alu_q, adr_q, rs2_q, pc4_q, ld_q;
   logic        mis_q;
   logic        accept, in_mem, in_mis, st_mem, st_wb;
   logic [2:0]  f3;
   logic [1:0]  wb_src;
   logic [4:0]  rd;
   logic [3:0]  be_raw;
   logic [31:0] wdata_raw, ld_ext, wb_sel;
   assign accept = ex_valid & ex_ready;
   assign in_mem = control_word_ex[11] | (control_word_ex[10:9] == 2'b01);
   // Misalignment is decided at accept so a bad access never reaches MEM.
   assign in_mis = in_mem & (((control_word_ex[1:0] == 2'b01) & calculated_adr[0]) |
                             ((control_word_ex[2:0] == 3'b010) & (calculated_adr[1:0] != 2'b00)));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cw_q  <= '0;
         alu_q <= '0;
         adr_q <= '0;
         rs2_q <= '0;
         pc4_q <= '0;
         ld_q  <= '0;
         mis_q <= 1'b0;
      end else if (accept) begin
         cw_q  <= control_word_ex;
         alu_q <= ALU_result;
         adr_q <= calculated_adr;
         rs2_q <= regfileb_ex;
         pc4_q <= pc_plus_4_ex;
         mis_q <= in_mis;
         state <= (in_mem & ~in_mis) ? MEM : WB;
      end else if (state == WB) begin
         state <= IDLE;
      end else if (state == MEM && dmem_ack) begin
         ld_q  <= dmem_rdata >> {adr_q[1:0], 3'b000};
         state <= WB;
      end
   end
   assign f3     = cw_q[2:0];
   assign wb_src = cw_q[10:9];
   assign rd     = cw_q[7:3];
   assign st_mem = state == MEM;
   assign st_wb  = state == WB;
   always_comb begin
      be_raw    = ~cw_q[11] ? 4'b1111 :
                  f3[1:0] == 2'b00 ? 4'b0001 << adr_q[1:0] :
                  f3[1:0] == 2'b01 ? 4'b0011 << adr_q[1:0] : 4'b1111;
      wdata_raw = f3[1:0] == 2'b00 ? {4{rs2_q[7:0]}} :
                  f3[1:0] == 2'b01 ? {2{rs2_q[15:0]}} : rs2_q;
      ld_ext    = f3 == 3'b000 ? {{24{ld_q[7]}}, ld_q[7:0]} :
                  f3 == 3'b001 ? {{16{ld_q[15]}}, ld_q[15:0]} :
                  f3 == 3'b100 ? {24'b0, ld_q[7:0]} :
                  f3 == 3'b101 ? {16'b0, ld_q[15:0]} : ld_q;
      wb_sel    = wb_src == 2'b00 ? alu_q :
                  wb_src == 2'b01 ? ld_ext :
                  wb_src == 2'b10 ? pc4_q : adr_q;
   end
   assign ex_ready       = ~st_mem;
   assign dmem_req       = st_mem;
   assign dmem_we        = st_mem & cw_q[11];
   assign dmem_addr      = st_mem ? {adr_q[31:2], 2'b00} : '0;
   assign dmem_be        = st_mem ? be_raw : '0;
   assign dmem_wdata     = st_mem ? wdata_raw : '0;
   assign wb_valid       = st_wb;
   assign wb_rf_we       = st_wb & cw_q[12] & (rd != 5'd0) & ~mis_q;
   assign wb_rd          = st_wb ? rd : '0;
   assign wb_data        = st_wb ? wb_sel : '0;
   assign misaligned     = st_wb & mis_q;
   assign redirect_valid = st_wb & (cw_q[13] | cw_q[8]);
   assign redirect_pc    = st_wb ? adr_q : '0;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage; inputs change and outputs are sampled on negedges.
module tb_memory_stage;
   logic        clk = 1'b0, rst = 1'b1, ex_valid = 1'b0, ex_ready;
   logic [13:0] control_word_ex = '0;
   logic [31:0] ALU_result = '0, calculated_adr = '0, regfileb_ex = '0, pc_plus_4_ex = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_rf_we, redirect_valid, misaligned;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, redirect_pc;
   int checks = 0, failures = 0;
   typedef struct {
      logic        rf_we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        dchk;
      logic        mis;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   memory_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .control_word_ex(control_word_ex), .ALU_result(ALU_result), .calculated_adr(calculated_adr),
      .regfileb_ex(regfileb_ex), .pc_plus_4_ex(pc_plus_4_ex),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misaligned(misaligned)
   );
   always #5 clk = ~clk;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [13:0] cw(logic bt, logic rfwb, logic we, logic [1:0] ws,
                                      logic pcs, logic [4:0] rd, logic [2:0] f3);
      return {bt, rfwb, we, ws, pcs, rd, f3};
   endfunction
   function automatic exp_t mk(logic rf_we, logic [4:0] rd, logic [31:0] data, logic dchk,
                               logic mis, logic redir, logic [31:0] rpc);
      exp_t x;
      x.rf_we = rf_we; x.rd = rd; x.data = data; x.dchk = dchk;
      x.mis = mis; x.redir = redir; x.rpc = rpc;
      return x;
   endfunction
   always @(negedge clk) begin
      if (wb_valid) begin
         if (sb.size() == 0) check("wb_unexpected", wb_valid, 1'b0);
         else begin
            e = sb.pop_front();
            check("wb_rf_we", wb_rf_we, e.rf_we);
            check("wb_rd", wb_rd, e.rd);
            if (e.dchk) check("wb_data", wb_data, e.data);
            check("misaligned", misaligned, e.mis);
            check("redirect_valid", redirect_valid, e.redir);
            if (e.redir) check("redirect_pc", redirect_pc, e.rpc);
         end
      end
   end
   // Called on a negedge with ex_ready high; returns on the following negedge.
   task automatic issue(logic [13:0] c, logic [31:0] alu, logic [31:0] adr,
                        logic [31:0] rs2, logic [31:0] pc4);
      ex_valid = 1'b1; control_word_ex = c; ALU_result = alu;
      calculated_adr = adr; regfileb_ex = rs2; pc_plus_4_ex = pc4;
      @(negedge clk);
      ex_valid = 1'b0;
   endtask
   task automatic serve(int n, logic [31:0] addr, logic [31:0] rdata);
      for (int i = 0; i < n; i++) begin
         check("req_hold", dmem_req, 1'b1);
         check("ready_in_mem", ex_ready, 1'b0);
         check("addr_hold", dmem_addr, addr);
         @(negedge clk);
      end
      check("req_at_ack", dmem_req, 1'b1);
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      dmem_ack = 1'b0;
   endtask
   typedef struct { logic [2:0] f3; logic [31:0] adr; logic [31:0] exp; } ld_t;
   typedef struct { logic [2:0] f3; logic [31:0] adr; logic [31:0] rs2; logic [3:0] be; logic [31:0] wd; } st_t;
   ld_t lds[5] = '{
      '{3'b100, 32'h11, 32'h000000BB}, '{3'b001, 32'h12, 32'hFFFF80AA},
      '{3'b101, 32'h12, 32'h000080AA}, '{3'b000, 32'h10, 32'hFFFFFFCC},
      '{3'b010, 32'h14, 32'h80AABBCC}};
   st_t sts[3] = '{
      '{3'b000, 32'h21, 32'h123456A5, 4'b0010, 32'hA5A5A5A5},
      '{3'b000, 32'h23, 32'h123456A5, 4'b1000, 32'hA5A5A5A5},
      '{3'b010, 32'h24, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF}};
   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
   initial begin
      logic [1:0]  ws;
      logic [4:0]  rd;
      logic        rfwb;
      logic [31:0] a, b, p;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", ex_ready, 1'b1);
      check("rst_req", dmem_req, 1'b0);
      check("rst_be", dmem_be, 4'b0);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_redirect", redirect_valid, 1'b0);
      check("rst_misaligned", misaligned, 1'b0);
      // ALU op, result one cycle after accept
      sb.push_back(mk(1, 5, 32'h12345678, 1, 0, 0, 0));
      issue(cw(0, 1, 0, 2'b00, 0, 5, 3'b000), 32'h12345678, 32'h0, 32'h0, 32'h0);
      check("alu_wb_valid", wb_valid, 1'b1);
      @(negedge clk);
      // lb at 0x1003, ack on third MEM cycle
      sb.push_back(mk(1, 7, 32'hFFFFFF80, 1, 0, 0, 0));
      issue(cw(0, 1, 0, 2'b01, 0, 7, 3'b000), 32'h0, 32'h1003, 32'h0, 32'h0);
      check("lb_addr", dmem_addr, 32'h1000);
      check("lb_be", dmem_be, 4'b1111);
      check("lb_we", dmem_we, 1'b0);
      serve(2, 32'h1000, 32'h80AABBCC);
      check("lb_wb_valid", wb_valid, 1'b1);
      @(negedge clk);
      // sh at 0x2002
      sb.push_back(mk(0, 0, 32'h55, 1, 0, 0, 0));
      issue(cw(0, 0, 1, 2'b00, 0, 0, 3'b001), 32'h55, 32'h2002, 32'h0000BEEF, 32'h0);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
      check("sh_we", dmem_we, 1'b1);
      serve(1, 32'h2000, 32'h0);
      @(negedge clk);
      // misaligned lw
      sb.push_back(mk(0, 3, 32'h0, 0, 1, 0, 0));
      issue(cw(0, 1, 0, 2'b01, 0, 3, 3'b010), 32'h0, 32'h0101, 32'h0, 32'h0);
      check("mis_no_req", dmem_req, 1'b0);
      check("mis_pulse", misaligned, 1'b1);
      @(negedge clk);
      check("mis_gone", misaligned, 1'b0);
      // taken branch then back-to-back ALU ops
      sb.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'h400));
      issue(cw(1, 0, 0, 2'b00, 0, 0, 3'b000), 32'h0, 32'h400, 32'h0, 32'h0);
      sb.push_back(mk(1, 1, 32'hA1, 1, 0, 0, 0));
      issue(cw(0, 1, 0, 2'b00, 0, 1, 3'b000), 32'hA1, 32'h0, 32'h0, 32'h0);
      check("b2b_first", wb_valid, 1'b1);
      sb.push_back(mk(1, 2, 32'hA2, 1, 0, 0, 0));
      issue(cw(0, 1, 0, 2'b00, 0, 2, 3'b000), 32'hA2, 32'h0, 32'h0, 32'h0);
      check("b2b_second", wb_valid, 1'b1);
      check("redirect_one_cycle", redirect_valid, 1'b0);
      @(negedge clk);
      // jal-like: pc_src redirect with pc+4 writeback; rd=0 suppresses write
      sb.push_back(mk(0, 0, 32'h104, 1, 0, 1, 32'h800));
      issue(cw(0, 1, 0, 2'b10, 1, 0, 3'b000), 32'h0, 32'h800, 32'h0, 32'h104);
      sb.push_back(mk(1, 9, 32'h3000, 1, 0, 0, 0));
      issue(cw(0, 1, 0, 2'b11, 0, 9, 3'b000), 32'h0, 32'h3000, 32'h0, 32'h0);
      @(negedge clk);
      foreach (lds[i]) begin
         sb.push_back(mk(1, 10, lds[i].exp, 1, 0, 0, 0));
         issue(cw(0, 1, 0, 2'b01, 0, 10, lds[i].f3), 32'h0, lds[i].adr, 32'h0, 32'h0);
         serve(0, {lds[i].adr[31:2], 2'b00}, 32'h80AABBCC);
      end
      @(negedge clk);
      foreach (sts[i]) begin
         sb.push_back(mk(0, 0, 32'h0, 1, 0, 0, 0));
         issue(cw(0, 0, 1, 2'b00, 0, 0, sts[i].f3), 32'h0, sts[i].adr, sts[i].rs2, 32'h0);
         check("st_be", dmem_be, sts[i].be);
         check("st_wdata", dmem_wdata, sts[i].wd);
         serve(1, {sts[i].adr[31:2], 2'b00}, 32'h0);
      end
      // random non-memory ops back to back
      for (int i = 0; i < 6; i++) begin
         ws = 2'($urandom_range(0, 2));
         if (ws != 2'b00) ws = ws + 2'd1;
         rd = 5'($urandom); rfwb = 1'($urandom);
         a = $urandom; b = $urandom; p = $urandom;
         sb.push_back(mk(rfwb & (rd != 0), rd, ws == 2'b00 ? a : ws == 2'b10 ? p : b, 1, 0, 0, 0));
         issue(cw(0, rfwb, 0, ws, 0, rd, 3'b000), a, b, 32'h0, p);
      end
      @(negedge clk);
      @(negedge clk);
      // stray ack while idle
      dmem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      check("stray_ack_ready", ex_ready, 1'b1);
      check("stray_ack_req", dmem_req, 1'b0);
      // reset while a load waits in MEM
      issue(cw(0, 1, 0, 2'b01, 0, 4, 3'b010), 32'h0, 32'h40, 32'h0, 32'h0);
      check("pre_rst_req", dmem_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mem_req", dmem_req, 1'b0);
      check("rst_mem_ready", ex_ready, 1'b1);
      check("rst_mem_wb", wb_valid, 1'b0);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
